// File: rtl/vend_ctrl_n.sv
// vend_ctrl_n: vending machine controller with per-slot stock, credit accumulation,
// coin overflow rejection, timed dispense/return phases and a one-shot buy lock.
// Ports: clk/rst (sync, active-high), power, op_start, coin_valid/coin_value, cancel,
//   buy[NUM_GOODS], restock in; on, occupy, avail, get_good, good_id, ret_coin,
//   ret_value, credit, coin_reject, status out. Every output is a flop.
module vend_ctrl_n #(
  parameter int NUM_GOODS   = 4,
  parameter int PRICE_STEP  = 5,
  parameter int STOCK_INIT  = 5,
  parameter int CREDIT_W    = 8,
  parameter int HOLD_CYCLES = 500000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 power,
  input  logic                 op_start,
  input  logic                 coin_valid,
  input  logic [CREDIT_W-1:0]  coin_value,
  input  logic                 cancel,
  input  logic [NUM_GOODS-1:0] buy,
  input  logic                 restock,
  output logic                 on,
  output logic                 occupy,
  output logic [NUM_GOODS-1:0] avail,
  output logic                 get_good,
  output logic [2:0]           good_id,
  output logic                 ret_coin,
  output logic [CREDIT_W-1:0]  ret_value,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 coin_reject,
  output logic [3:0]           status
);

  localparam int CNT_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_IDLE     = 3'd1,
    S_SELECT   = 3'd2,
    S_DISPENSE = 3'd3,
    S_RETURN   = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [CREDIT_W-1:0]  credit_n;
  logic [7:0]           stock   [NUM_GOODS];
  logic [7:0]           stock_n [NUM_GOODS];
  logic                 lock, lock_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [2:0]           good_id_n;
  logic [CREDIT_W-1:0]  ret_n;
  logic                 reject_n;
  logic [NUM_GOODS-1:0] avail_n;

  logic [CREDIT_W-1:0]  price [NUM_GOODS];
  logic [CREDIT_W-1:0]  price_sel;
  logic [2:0]           buy_idx;
  logic                 abort;
  logic                 take_buy;
  logic [CREDIT_W-1:0]  base;
  logic [CREDIT_W:0]    coin_sum;
  logic [CREDIT_W-1:0]  after_coin;
  logic                 coin_ovf;

  genvar g;
  generate
    for (g = 0; g < NUM_GOODS; g++) begin : g_price
      assign price[g] = CREDIT_W'((g + 1) * PRICE_STEP);
    end
  endgenerate

  // Slot index and price of the requested slot; only meaningful when buy is one-hot.
  always_comb begin
    buy_idx   = 3'd0;
    price_sel = '0;
    for (int i = 0; i < NUM_GOODS; i++) begin
      if (buy[i]) begin
        buy_idx   = 3'(i);
        price_sel = price[i];
      end
    end
  end

  assign abort = cancel || !power;

  // avail is the registered view the customer sees, so acceptance is judged against it.
  assign take_buy = (state == S_SELECT) && !abort && $onehot(buy) &&
                    (|(buy & avail)) && !lock;

  // Coin is applied after any price deduction, and the overflow test sees that result.
  assign base       = take_buy ? (credit - price_sel) : credit;
  assign coin_sum   = {1'b0, base} + {1'b0, coin_value};
  assign coin_ovf   = coin_sum[CREDIT_W];
  assign after_coin = (coin_valid && !coin_ovf) ? coin_sum[CREDIT_W-1:0] : base;

  always_comb begin
    state_n   = state;
    credit_n  = credit;
    stock_n   = stock;
    lock_n    = lock;
    cnt_n     = cnt;
    good_id_n = good_id;
    ret_n     = '0;
    reject_n  = 1'b0;

    case (state)
      S_OFF: begin
        good_id_n = 3'd0;
        if (restock) begin
          for (int i = 0; i < NUM_GOODS; i++) stock_n[i] = 8'(STOCK_INIT);
        end
        if (power) state_n = S_IDLE;
      end

      S_IDLE: begin
        reject_n = coin_valid;
        if (restock) begin
          for (int i = 0; i < NUM_GOODS; i++) stock_n[i] = 8'(STOCK_INIT);
        end
        if (op_start)    state_n = S_SELECT;
        else if (!power) state_n = S_OFF;
      end

      S_SELECT: begin
        reject_n = coin_valid && coin_ovf;
        if (abort) begin
          // A coin in the same cycle as cancel is still honoured and returned.
          state_n  = S_RETURN;
          ret_n    = after_coin;
          credit_n = '0;
          cnt_n    = '0;
        end else if (take_buy) begin
          state_n   = S_DISPENSE;
          credit_n  = after_coin;
          good_id_n = buy_idx;
          lock_n    = 1'b1;
          cnt_n     = '0;
          for (int i = 0; i < NUM_GOODS; i++) begin
            if (buy[i]) stock_n[i] = stock[i] - 8'd1;
          end
        end else begin
          credit_n = after_coin;
        end
      end

      S_DISPENSE: begin
        reject_n = coin_valid;
        cnt_n    = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          // Power loss while dispensing is deferred to here; credit goes back to the customer.
          if (!power) begin
            state_n  = S_RETURN;
            ret_n    = credit;
            credit_n = '0;
          end else if (credit != '0) begin
            state_n = S_SELECT;
          end else begin
            state_n = S_IDLE;
          end
        end
      end

      S_RETURN: begin
        reject_n = coin_valid;
        ret_n    = ret_value;
        cnt_n    = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          ret_n   = '0;
          state_n = power ? S_IDLE : S_OFF;
        end
      end

      default: state_n = S_OFF;
    endcase

    // A held request buys once: the lock only drops once buy is fully released.
    if (buy == '0) lock_n = 1'b0;
  end

  always_comb begin
    avail_n = '0;
    for (int i = 0; i < NUM_GOODS; i++) begin
      avail_n[i] = (state_n == S_SELECT) && (credit_n >= price[i]) && (stock_n[i] != 8'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_OFF;
      credit      <= '0;
      for (int i = 0; i < NUM_GOODS; i++) stock[i] <= 8'(STOCK_INIT);
      lock        <= 1'b0;
      cnt         <= '0;
      on          <= 1'b0;
      occupy      <= 1'b0;
      avail       <= '0;
      get_good    <= 1'b0;
      good_id     <= 3'd0;
      ret_coin    <= 1'b0;
      ret_value   <= '0;
      coin_reject <= 1'b0;
      status      <= 4'd0;
    end else begin
      state       <= state_n;
      credit      <= credit_n;
      stock       <= stock_n;
      lock        <= lock_n;
      cnt         <= cnt_n;
      on          <= (state_n != S_OFF);
      occupy      <= (state_n == S_SELECT) || (state_n == S_DISPENSE) || (state_n == S_RETURN);
      avail       <= avail_n;
      get_good    <= (state_n == S_DISPENSE);
      good_id     <= good_id_n;
      ret_coin    <= (state_n == S_RETURN);
      ret_value   <= ret_n;
      coin_reject <= reject_n;
      status      <= {1'b0, state_n};
    end
  end

endmodule

// File: tb/tb_vend_ctrl_n.sv
// tb_vend_ctrl_n: directed scenarios for vend_ctrl_n with small parameters
// (4 slots, price step 5, stock 2, hold 4 cycles, 8-bit credit).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_vend_ctrl_n;

  logic       clk = 1'b0;
  logic       rst, power, op_start, coin_valid, cancel, restock;
  logic [7:0] coin_value;
  logic [3:0] buy;
  logic       on, occupy, get_good, ret_coin, coin_reject;
  logic [3:0] avail, status;
  logic [2:0] good_id;
  logic [7:0] ret_value, credit;

  int vectors = 0;
  int errors  = 0;
  int cnt_a, cnt_b;
  logic prev_gg;

  vend_ctrl_n #(
    .NUM_GOODS(4), .PRICE_STEP(5), .STOCK_INIT(2), .CREDIT_W(8), .HOLD_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .power(power), .op_start(op_start),
    .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel),
    .buy(buy), .restock(restock), .on(on), .occupy(occupy), .avail(avail),
    .get_good(get_good), .good_id(good_id), .ret_coin(ret_coin),
    .ret_value(ret_value), .credit(credit), .coin_reject(coin_reject),
    .status(status)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [7:0] v);
    coin_valid = 1'b1;
    coin_value = v;
    tick();
    coin_valid = 1'b0;
    coin_value = 8'd0;
  endtask

  task automatic test_reset;
    rst = 1'b1; power = 1'b0; op_start = 1'b0; coin_valid = 1'b0; coin_value = 8'd0;
    cancel = 1'b0; buy = 4'b0; restock = 1'b0;
    repeat (2) tick();
    vectors++;
    if ({on, occupy, avail, get_good, good_id, ret_coin, ret_value, credit, coin_reject, status} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got status=%0d on=%0b credit=%0d exp all zero", status, on, credit);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (status !== 4'd0 || on !== 1'b0) begin
      errors++; $display("FAIL off_hold got status=%0d on=%0b exp 0/0", status, on);
    end
  endtask

  task automatic test_power_idle;
    power = 1'b1;
    tick();
    vectors++;
    if (status !== 4'd1 || on !== 1'b1 || occupy !== 1'b0) begin
      errors++; $display("FAIL idle_entry got status=%0d on=%0b occupy=%0b exp 1/1/0", status, on, occupy);
    end
    coin(8'd5);
    vectors++;
    if (coin_reject !== 1'b1 || credit !== 8'd0) begin
      errors++; $display("FAIL idle_coin got reject=%0b credit=%0d exp 1/0", coin_reject, credit);
    end
    tick();
    vectors++;
    if (coin_reject !== 1'b0) begin
      errors++; $display("FAIL reject_pulse got %0b exp 0", coin_reject);
    end
  endtask

  task automatic test_single_buy;
    op_start = 1'b1; tick(); op_start = 1'b0;
    vectors++;
    if (status !== 4'd2 || occupy !== 1'b1 || avail !== 4'b0000) begin
      errors++; $display("FAIL select_entry got status=%0d occupy=%0b avail=%b exp 2/1/0000", status, occupy, avail);
    end
    coin(8'd10);
    vectors++;
    if (credit !== 8'd10 || avail !== 4'b0011) begin
      errors++; $display("FAIL coin10 got credit=%0d avail=%b exp 10/0011", credit, avail);
    end
    buy = 4'b0010;
    tick();
    vectors++;
    if (get_good !== 1'b1 || good_id !== 3'd1 || credit !== 8'd0) begin
      errors++; $display("FAIL buy1 got gg=%0b id=%0d credit=%0d exp 1/1/0", get_good, good_id, credit);
    end
    cnt_a = 1; cnt_b = 1; prev_gg = 1'b1;
    repeat (9) begin
      tick();
      if (get_good) cnt_a++;
      if (get_good && !prev_gg) cnt_b++;
      prev_gg = get_good;
    end
    vectors++;
    if (cnt_a != 4 || cnt_b != 1) begin
      errors++; $display("FAIL held_buy got gg_cycles=%0d dispenses=%0d exp 4/1", cnt_a, cnt_b);
    end
    vectors++;
    if (status !== 4'd1 || credit !== 8'd0) begin
      errors++; $display("FAIL after_dispense got status=%0d credit=%0d exp 1/0", status, credit);
    end
    buy = 4'b0;
    tick();
  endtask

  task automatic test_two_buys;
    op_start = 1'b1; tick(); op_start = 1'b0;
    coin(8'd20);
    vectors++;
    if (credit !== 8'd20 || avail !== 4'b1111) begin
      errors++; $display("FAIL coin20 got credit=%0d avail=%b exp 20/1111", credit, avail);
    end
    buy = 4'b0001; tick(); buy = 4'b0;
    vectors++;
    if (get_good !== 1'b1 || credit !== 8'd15) begin
      errors++; $display("FAIL buy0_first got gg=%0b credit=%0d exp 1/15", get_good, credit);
    end
    repeat (4) tick();
    vectors++;
    if (status !== 4'd2 || avail !== 4'b0111) begin
      errors++; $display("FAIL back_to_select got status=%0d avail=%b exp 2/0111", status, avail);
    end
    buy = 4'b0001; tick(); buy = 4'b0;
    vectors++;
    if (get_good !== 1'b1 || credit !== 8'd10) begin
      errors++; $display("FAIL buy0_second got gg=%0b credit=%0d exp 1/10", get_good, credit);
    end
    repeat (4) tick();
    vectors++;
    if (status !== 4'd2 || credit !== 8'd10 || avail !== 4'b0010) begin
      errors++; $display("FAIL stock_empty got status=%0d credit=%0d avail=%b exp 2/10/0010", status, credit, avail);
    end
    buy = 4'b0001; tick(); buy = 4'b0;
    vectors++;
    if (status !== 4'd2 || get_good !== 1'b0 || credit !== 8'd10) begin
      errors++; $display("FAIL third_buy got status=%0d gg=%0b credit=%0d exp 2/0/10", status, get_good, credit);
    end
  endtask

  task automatic test_overflow_cancel;
    coin(8'd240);
    vectors++;
    if (credit !== 8'd250 || coin_reject !== 1'b0) begin
      errors++; $display("FAIL coin240 got credit=%0d reject=%0b exp 250/0", credit, coin_reject);
    end
    coin(8'd10);
    vectors++;
    if (coin_reject !== 1'b1 || credit !== 8'd250) begin
      errors++; $display("FAIL overflow got reject=%0b credit=%0d exp 1/250", coin_reject, credit);
    end
    tick();
    cancel = 1'b1; tick(); cancel = 1'b0;
    vectors++;
    if (status !== 4'd4 || ret_coin !== 1'b1 || ret_value !== 8'd250 || credit !== 8'd0) begin
      errors++; $display("FAIL cancel got status=%0d ret=%0b val=%0d credit=%0d exp 4/1/250/0", status, ret_coin, ret_value, credit);
    end
    cnt_a = 1;
    repeat (3) begin
      tick();
      if (ret_coin && ret_value == 8'd250) cnt_a++;
    end
    tick();
    vectors++;
    if (cnt_a != 4 || status !== 4'd1 || ret_coin !== 1'b0 || ret_value !== 8'd0) begin
      errors++; $display("FAIL return_hold got cycles=%0d status=%0d ret=%0b val=%0d exp 4/1/0/0", cnt_a, status, ret_coin, ret_value);
    end
  endtask

  task automatic test_same_cycle;
    restock = 1'b1; tick(); restock = 1'b0;
    op_start = 1'b1; tick(); op_start = 1'b0;
    coin(8'd5);
    vectors++;
    if (credit !== 8'd5 || avail !== 4'b0001) begin
      errors++; $display("FAIL restock_avail got credit=%0d avail=%b exp 5/0001", credit, avail);
    end
    coin_valid = 1'b1; coin_value = 8'd5; buy = 4'b0001; cancel = 1'b1;
    tick();
    coin_valid = 1'b0; coin_value = 8'd0; buy = 4'b0; cancel = 1'b0;
    vectors++;
    if (status !== 4'd4 || ret_value !== 8'd10 || get_good !== 1'b0) begin
      errors++; $display("FAIL priority got status=%0d val=%0d gg=%0b exp 4/10/0", status, ret_value, get_good);
    end
    repeat (4) tick();
    op_start = 1'b1; tick(); op_start = 1'b0;
    coin(8'd10);
    buy = 4'b0001; tick(); buy = 4'b0;
    repeat (4) tick();
    // slot 0 only remains available here if the cancelled buy left its stock alone
    vectors++;
    if (status !== 4'd2 || credit !== 8'd5 || avail !== 4'b0001) begin
      errors++; $display("FAIL stock_kept got status=%0d credit=%0d avail=%b exp 2/5/0001", status, credit, avail);
    end
    buy = 4'b0001; tick(); buy = 4'b0;
    repeat (4) tick();
    vectors++;
    if (status !== 4'd1 || credit !== 8'd0) begin
      errors++; $display("FAIL empty_to_idle got status=%0d credit=%0d exp 1/0", status, credit);
    end
  endtask

  task automatic test_reset_dispense;
    op_start = 1'b1; tick(); op_start = 1'b0;
    coin(8'd10);
    buy = 4'b0010; tick(); buy = 4'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    vectors++;
    if ({on, occupy, avail, get_good, good_id, ret_coin, ret_value, credit, coin_reject, status} !== '0) begin
      errors++; $display("FAIL mid_reset got status=%0d gg=%0b credit=%0d exp all zero", status, get_good, credit);
    end
    tick();
    op_start = 1'b1; tick(); op_start = 1'b0;
    coin(8'd20);
    vectors++;
    if (credit !== 8'd20 || avail !== 4'b1111) begin
      errors++; $display("FAIL stock_restored got credit=%0d avail=%b exp 20/1111", credit, avail);
    end
  endtask

  task automatic test_multi_power;
    buy = 4'b0011; tick(); buy = 4'b0;
    vectors++;
    if (status !== 4'd2 || get_good !== 1'b0 || credit !== 8'd20) begin
      errors++; $display("FAIL multi_buy got status=%0d gg=%0b credit=%0d exp 2/0/20", status, get_good, credit);
    end
    tick();
    buy = 4'b0001; tick(); buy = 4'b0;
    repeat (4) tick();
    power = 1'b0; tick();
    vectors++;
    if (status !== 4'd4 || ret_value !== 8'd15 || ret_coin !== 1'b1) begin
      errors++; $display("FAIL power_off got status=%0d val=%0d ret=%0b exp 4/15/1", status, ret_value, ret_coin);
    end
    repeat (4) tick();
    vectors++;
    if (status !== 4'd0 || on !== 1'b0 || ret_coin !== 1'b0) begin
      errors++; $display("FAIL to_off got status=%0d on=%0b ret=%0b exp 0/0/0", status, on, ret_coin);
    end
  endtask

  task automatic test_zero_return;
    power = 1'b1; tick();
    power = 1'b0; op_start = 1'b1; tick(); op_start = 1'b0;
    vectors++;
    if (status !== 4'd2) begin
      errors++; $display("FAIL start_priority got status=%0d exp 2", status);
    end
    power = 1'b1; cancel = 1'b1; tick(); cancel = 1'b0; power = 1'b0;
    repeat (3) tick();
    vectors++;
    if (status !== 4'd4 || ret_coin !== 1'b1 || ret_value !== 8'd0) begin
      errors++; $display("FAIL zero_return got status=%0d ret=%0b val=%0d exp 4/1/0", status, ret_coin, ret_value);
    end
    tick();
    vectors++;
    if (status !== 4'd0 || ret_coin !== 1'b0) begin
      errors++; $display("FAIL zero_return_end got status=%0d ret=%0b exp 0/0", status, ret_coin);
    end
  endtask

  initial begin
    test_reset();
    test_power_idle();
    test_single_buy();
    test_two_buys();
    test_overflow_cancel();
    test_same_cycle();
    test_reset_dispense();
    test_multi_power();
    test_zero_return();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
